// File: rtl/avr_uart_io.sv
// avr_uart_io: memory-mapped 8N1 UART peripheral with TX FIFO, 2-entry RX buffer and IRQs
module avr_uart_io #(
  parameter logic [15:0] BASE = 16'h0020,
  parameter int TX_DEPTH_LOG2 = 2,
  parameter logic [15:0] BAUD_RESET = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  wb,
  input  logic        w,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        sel,
  output logic        txd,
  input  logic        rxd,
  output logic        irq_rx,
  output logic        irq_tx
);
  localparam int AW = TX_DEPTH_LOG2;
  localparam int TD = 1 << AW;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [15:0] off16, div;
  logic [2:0] off;
  logic [3:0] ctrl;
  logic [7:0] status;
  logic wr_data, wr_stat, ferr, ovr, txovf;
  assign off16 = address - BASE;
  assign sel = off16 < 16'd5;
  assign off = off16[2:0];
  assign wr_data = w & sel & (off == 3'd0);
  assign wr_stat = w & sel & (off == 3'd1);
  logic [7:0] tf [TD];
  logic [AW-1:0] twp, trp;
  logic [AW:0] tcnt;
  logic t_empty, t_full, t_push, t_pop, t_bnd, t_go;
  state_t ts, ts_n;
  logic [15:0] tc, tdiv;
  logic [2:0] tbit;
  logic [7:0] tsh;
  assign t_empty = tcnt == '0;
  assign t_full = tcnt == (AW+1)'(TD);
  assign t_push = wr_data & (!t_full | t_pop);
  assign t_bnd = tc == tdiv;
  assign t_go = ctrl[2] & !t_empty;
  always_comb begin
    ts_n = ts;
    t_pop = 1'b0;
    case (ts)
      IDLE: begin
        ts_n = t_go ? START : IDLE;
        t_pop = t_go;
      end
      START: ts_n = t_bnd ? DATA : START;
      DATA: ts_n = (t_bnd && tbit == 3'd7) ? STOP : DATA;
      STOP: begin
        ts_n = !t_bnd ? STOP : t_go ? START : IDLE;
        t_pop = t_bnd & t_go;
      end
    endcase
  end
  logic s1, s2, s3;
  state_t rs, rs_n;
  logic [15:0] rc, rdiv;
  logic [2:0] rbit;
  logic [7:0] rsh;
  logic [7:0] rb [2];
  logic rrp;
  logic [1:0] rcnt;
  logic r_half, r_bnd, r_tick, r_store, r_ferr, r_ok, rd_pop;
  assign r_half = rc == (rdiv >> 1);
  assign r_bnd = rc == rdiv;
  assign r_tick = (rs == START) ? r_half : r_bnd;
  assign rd_pop = rd & sel & (off == 3'd0) & (rcnt != 2'd0);
  assign r_ok = r_store & ((rcnt != 2'd2) | rd_pop);
  always_comb begin
    rs_n = rs;
    r_store = 1'b0;
    r_ferr = 1'b0;
    case (rs)
      IDLE: rs_n = (ctrl[3] & s3 & !s2) ? START : IDLE;
      START: rs_n = !r_half ? START : s2 ? IDLE : DATA;
      DATA: rs_n = (r_bnd && rbit == 3'd7) ? STOP : DATA;
      STOP: begin
        rs_n = r_bnd ? IDLE : STOP;
        r_store = r_bnd & s2;
        r_ferr = r_bnd & !s2;
      end
    endcase
  end
  // Each engine reloads its private divisor copy at every bit boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts <= IDLE;
      tc <= '0;
      tdiv <= BAUD_RESET;
      tbit <= '0;
      tsh <= '0;
      txd <= 1'b1;
      twp <= '0;
      trp <= '0;
      tcnt <= '0;
      {s1, s2, s3} <= 3'b111;
      rs <= IDLE;
      rc <= '0;
      rdiv <= BAUD_RESET;
      rbit <= '0;
      rsh <= '0;
      rrp <= 1'b0;
      rcnt <= '0;
      ctrl <= '0;
      div <= BAUD_RESET;
      {ferr, ovr, txovf} <= 3'b000;
      irq_rx <= 1'b0;
      irq_tx <= 1'b0;
    end else begin
      ts <= ts_n;
      tc <= (ts == IDLE || t_bnd) ? '0 : tc + 16'd1;
      if (ts == IDLE || t_bnd) tdiv <= div;
      if (t_pop) tsh <= tf[trp];
      else if (ts == DATA && t_bnd) tsh <= tsh >> 1;
      if (ts == DATA && t_bnd) tbit <= tbit + 3'd1;
      txd <= (ts == START) ? 1'b0 : (ts == DATA) ? tsh[0] : 1'b1;
      if (t_push) twp <= twp + AW'(1);
      if (t_pop) trp <= trp + AW'(1);
      tcnt <= tcnt + (AW+1)'(t_push) - (AW+1)'(t_pop);
      {s3, s2, s1} <= {s2, s1, rxd};
      rs <= rs_n;
      rc <= (rs == IDLE || r_tick) ? '0 : rc + 16'd1;
      if (rs == IDLE || r_tick) rdiv <= div;
      if (rs == DATA && r_bnd) begin
        rsh <= {s2, rsh[7:1]};
        rbit <= rbit + 3'd1;
      end
      if (rd_pop) rrp <= ~rrp;
      rcnt <= rcnt + 2'(r_ok) - 2'(rd_pop);
      if (w & sel & (off == 3'd2)) ctrl <= wb[3:0];
      if (w & sel & (off == 3'd3)) div[7:0] <= wb;
      if (w & sel & (off == 3'd4)) div[15:8] <= wb;
      ferr <= r_ferr | (ferr & !wr_stat);
      ovr <= (r_store & !r_ok) | (ovr & !wr_stat);
      txovf <= (wr_data & !t_push) | (txovf & !wr_stat);
      irq_rx <= ctrl[0] & (rcnt != 2'd0);
      irq_tx <= ctrl[1] & t_empty;
    end
  end
  always_ff @(posedge clock) begin
    if (t_push) tf[twp] <= wb;
    if (r_ok) rb[rrp ^ rcnt[0]] <= rsh;
  end
  assign status = {2'b00, txovf, ovr, ferr, t_full, t_empty & (ts == IDLE), rcnt != 2'd0};
  always_comb
    dout = !sel ? 8'h00 :
           (off == 3'd0) ? ((rcnt == 2'd0) ? 8'h00 : rb[rrp]) :
           (off == 3'd1) ? status :
           (off == 3'd2) ? {4'b0000, ctrl} :
           (off == 3'd3) ? div[7:0] : div[15:8];
endmodule

// File: tb/tb_avr_uart_io.sv
// tb_avr_uart_io: randomized bus/serial stimulus checked against a frame-level UART model
module tb_avr_uart_io;
  localparam logic [15:0] BASE = 16'h0020;
  logic clock = 1'b0, reset = 1'b1, w = 1'b0, rd = 1'b0, rxd = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0] wb = 8'h00, dout;
  logic sel, txd, irq_rx, irq_tx;
  avr_uart_io #(.BASE(BASE), .TX_DEPTH_LOG2(2), .BAUD_RESET(16'd433)) dut (
    .clock(clock), .reset(reset), .address(address), .wb(wb), .w(w), .rd(rd),
    .dout(dout), .sel(sel), .txd(txd), .rxd(rxd), .irq_rx(irq_rx), .irq_tx(irq_tx));
  always #5 clock = ~clock;
  int tests = 0, fails = 0, cyc = 0, mp = 434, t0 = 0;
  bit mon_act = 0;
  logic [9:0] fr;
  logic [9:0] frames[$];
  int starts[$];
  logic [7:0] q[$];
  bit m_ovr = 0, m_ferr = 0;
  always @(posedge clock) cyc <= cyc + 1;
  // Frame decoder on txd: samples every bit at its middle relative to the start edge
  always @(negedge clock) begin
    if (reset) mon_act = 0;
    else if (!mon_act && txd == 1'b0) begin
      mon_act = 1;
      t0 = cyc;
    end
    if (mon_act && !reset && ((cyc - t0) % mp) == mp / 2) begin
      fr[(cyc - t0) / mp] = txd;
      if ((cyc - t0) / mp == 9) begin
        frames.push_back(fr);
        starts.push_back(t0);
        mon_act = 0;
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    @(negedge clock);
    address = BASE + 16'(o);
    wb = d;
    w = 1'b1;
    @(negedge clock);
    w = 1'b0;
    address = 16'h0000;
  endtask
  task automatic rdreg(input logic [2:0] o, input logic pop, output logic [7:0] d);
    @(negedge clock);
    address = BASE + 16'(o);
    rd = pop;
    #1 d = dout;
    @(negedge clock);
    rd = 1'b0;
    address = 16'h0000;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int p);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (p) @(negedge clock);
    end
    rxd = 1'b1;
    repeat (p) @(negedge clock);
  endtask
  task automatic rx_model(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1;
    else if (q.size() < 2) q.push_back(b);
    else m_ovr = 1;
  endtask
  function automatic logic [7:0] rx_stat();
    return {3'b000, m_ovr, m_ferr, 2'b01, q.size() != 0};
  endfunction
  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frames.size() < n && k < 3000) begin
      @(negedge clock);
      k++;
    end
    chk("tx_frame_count", frames.size(), n);
  endtask
  task automatic wait_txempty();
    logic [7:0] s;
    int k;
    k = 0;
    s = 8'h00;
    while (!s[1] && k < 1000) begin
      rdreg(3'd1, 1'b0, s);
      k++;
    end
    chk("txempty", s[1], 1);
  endtask
  task automatic chk_frames(input logic [7:0] e[$], input int n);
    for (int i = 0; i < n && i < frames.size(); i++) begin
      chk("tx_frame", frames[i], {1'b1, e[i], 1'b0});
      if (i > 0) chk("tx_gap", starts[i] - starts[i-1], 10 * mp);
    end
  endtask
  initial begin
    logic [7:0] s, d, e;
    logic [7:0] ex[$];
    int n, p;
    logic stop;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    rdreg(3'd1, 1'b0, s); chk("rst_status", s, 8'h02);
    chk("rst_txd", txd, 1);
    chk("rst_irq_rx", irq_rx, 0);
    chk("rst_irq_tx", irq_tx, 0);
    rdreg(3'd3, 1'b0, s); chk("rst_baud_lo", s, 8'hB1);
    rdreg(3'd4, 1'b0, s); chk("rst_baud_hi", s, 8'h01);
    rdreg(3'd2, 1'b0, s); chk("rst_ctrl", s, 8'h00);
    @(negedge clock);
    address = BASE + 16'd5;
    #1 chk("out_hi_sel", sel, 0); chk("out_hi_dout", dout, 8'h00);
    address = BASE - 16'd1;
    #1 chk("out_lo_sel", sel, 0); chk("out_lo_dout", dout, 8'h00);
    address = 16'h0000;
    wr(3'd3, 8'd3); wr(3'd4, 8'd0); mp = 4; wr(3'd2, 8'h04);
    frames.delete(); starts.delete();
    wr(3'd0, 8'hA5);
    wait_frames(1);
    ex.delete(); ex.push_back(8'hA5);
    chk_frames(ex, 1);
    wait_txempty();
    wr(3'd2, 8'h00);
    ex.delete();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      ex.push_back(d);
      wr(3'd0, d);
    end
    rdreg(3'd1, 1'b0, s); chk("full_status", s, 8'h24);
    frames.delete(); starts.delete();
    wr(3'd2, 8'h04);
    wait_frames(4);
    chk_frames(ex, 4);
    wait_txempty();
    repeat (12 * mp) @(negedge clock);
    chk("fifo_drop_count", frames.size(), 4);
    rdreg(3'd1, 1'b0, s); chk("txovf_sticky", s, 8'h22);
    wr(3'd1, 8'hFF);
    rdreg(3'd1, 1'b0, s); chk("txovf_clear", s, 8'h02);
    wr(3'd2, 8'h06);
    repeat (2) @(negedge clock);
    chk("irq_tx_on", irq_tx, 1);
    wr(3'd2, 8'h04);
    repeat (2) @(negedge clock);
    chk("irq_tx_off", irq_tx, 0);
    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(1, 5);
      wr(3'd3, 8'(p - 1)); wr(3'd4, 8'd0);
      mp = p;
      frames.delete(); starts.delete(); ex.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        ex.push_back(d);
        wr(3'd0, d);
      end
      wait_frames(n);
      chk_frames(ex, n);
      wait_txempty();
      rdreg(3'd1, 1'b0, s); chk("tx_round_status", s, 8'h02);
    end
    wr(3'd3, 8'd7); wr(3'd4, 8'd0); wr(3'd2, 8'h09);
    q.delete(); m_ovr = 0; m_ferr = 0;
    send(8'h3C, 1'b1, 8); rx_model(8'h3C, 1'b1);
    rdreg(3'd1, 1'b0, s); chk("rx_status", s, rx_stat());
    chk("irq_rx_on", irq_rx, 1);
    rdreg(3'd0, 1'b1, d); chk("rx_data", d, q.pop_front());
    rdreg(3'd1, 1'b0, s); chk("rx_popped", s, rx_stat());
    @(negedge clock);
    chk("irq_rx_off", irq_rx, 0);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send(d, 1'b1, 8); rx_model(d, 1'b1);
    end
    rdreg(3'd1, 1'b0, s); chk("rx_ovr_status", s, rx_stat());
    for (int i = 0; i < 2; i++) begin
      rdreg(3'd0, 1'b1, d); chk("rx_order", d, q.pop_front());
    end
    wr(3'd1, 8'h00); m_ovr = 0; m_ferr = 0;
    @(negedge clock); rxd = 1'b0;
    @(negedge clock); rxd = 1'b1;
    repeat (40) @(negedge clock);
    rdreg(3'd1, 1'b0, s); chk("rx_glitch", s, rx_stat());
    d = 8'($urandom); e = 8'($urandom);
    send(d, 1'b1, 8); rx_model(d, 1'b1);
    send(e, 1'b0, 8); rx_model(e, 1'b0);
    rdreg(3'd1, 1'b0, s); chk("rx_ferr", s, rx_stat());
    wr(3'd1, 8'h00); m_ovr = 0; m_ferr = 0;
    rdreg(3'd1, 1'b0, s); chk("rx_ferr_clear", s, rx_stat());
    for (int i = 0; i < 10; i++) begin
      p = $urandom_range(4, 10);
      wr(3'd3, 8'(p - 1));
      d = 8'($urandom);
      stop = $urandom_range(0, 5) != 0;
      send(d, stop, p); rx_model(d, stop);
      if ($urandom_range(0, 1) == 1) begin
        e = (q.size() != 0) ? q.pop_front() : 8'h00;
        rdreg(3'd0, 1'b1, d); chk("rx_rand_data", d, e);
      end
      rdreg(3'd1, 1'b0, s); chk("rx_rand_status", s, rx_stat());
    end
    wr(3'd3, 8'd7); wr(3'd2, 8'h04); mp = 8;
    wr(3'd0, 8'h5A); wr(3'd0, 8'hC3);
    repeat (30) @(negedge clock);
    rdreg(3'd1, 1'b0, s); chk("busy_status", s[1], 0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rst_mid_txd", txd, 1);
    rdreg(3'd1, 1'b0, s); chk("rst_mid_status", s, 8'h02);
    reset = 1'b0;
    rdreg(3'd1, 1'b0, s); chk("post_rst_status", s, 8'h02);
    rdreg(3'd3, 1'b0, s); chk("post_rst_baud", s, 8'hB1);
    chk("post_rst_txd", txd, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
